ttl_input_timestamper: RTL and testbench

Real-time input (RTI) counterpart of the timed TTL output path. Samples one asynchronous TTL input line, detects rising and/or falling edges, and tags each edge with the 64-bit TimeController counter. Buffers the tagged events in a FIFO that an AXI2FIFO-style reader drains. The entry layout mirrors the RTO word, so software reads back the format it writes.

---
 rtl/ttl_rti_pkg.sv | 26 ++
 rtl/ttl_rti_fifo.sv | 82 ++++++++
 rtl/ttl_input_timestamper.sv | 102 ++++++++++
 tb/tb_ttl_input_timestamper.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_rti_pkg.sv
// Shared types and word layout for the real-time TTL input timestamper.
// The packed read word mirrors the timed-output word so software sees one format.
package ttl_rti_pkg;

    localparam int RTI_WORD_WIDTH = 128;
    localparam int TS_LSB         = 8;
    localparam int TS_MSB         = 71;
    localparam int EDGE_BIT       = 0;

    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;

    typedef struct packed {
        logic [63:0] timestamp;
        logic        rising;
    } rti_entry_t;

    function automatic logic [RTI_WORD_WIDTH-1:0] rti_pack(input rti_entry_t e);
        logic [RTI_WORD_WIDTH-1:0] w;
        w                = '0;
        w[TS_MSB:TS_LSB] = e.timestamp;
        w[EDGE_BIT]      = e.rising;
        return w;
    endfunction

endpackage

// File: rtl/ttl_rti_fifo.sv
// Synchronous first-word-fall-through FIFO: RAM array plus one output register.
// fill count covers the RAM entries and the output register together.
module ttl_rti_fifo #(
    parameter int DEPTH_LOG2 = 9,
    parameter int DATA_W     = 65
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_W-1:0]     i_push_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_drop
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_mcnt;
    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;

    logic                  w_pop;
    logic                  w_wr;
    logic                  w_load;
    logic [DEPTH_LOG2:0]   w_count;

    assign w_count = r_mcnt + {{DEPTH_LOG2{1'b0}}, r_valid};
    assign w_pop   = r_valid & i_pop;
    assign o_full  = (w_count == FULL_CNT);
    assign o_empty = (w_count == '0);
    assign o_count = w_count;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_wr   = i_push & ~i_flush & (~o_full | w_pop);
    assign w_load = (r_mcnt != '0) & (~r_valid | w_pop);
    assign o_drop = i_push & ~i_flush & ~w_wr;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_mcnt  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_mcnt  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_load) begin
                r_rptr  <= r_rptr + 1'b1;
                r_data  <= r_mem[r_rptr];
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            r_mcnt <= r_mcnt + {{DEPTH_LOG2{1'b0}}, w_wr} - {{DEPTH_LOG2{1'b0}}, w_load};
        end
    end

endmodule

// File: rtl/ttl_input_timestamper.sv
// Synchronises one TTL input, detects edges, tags them with the time counter
// and queues them for the reader, tracking the first dropped event.
module ttl_input_timestamper
    import ttl_rti_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 9,
    parameter int LATENCY_COMP    = 2,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic                        ttl_in,
    input  logic [63:0]                 counter,
    input  logic                        capture_en,
    input  logic [1:0]                  edge_mode,
    input  logic                        flush,
    input  logic                        rd_ready,
    output logic                        rd_valid,
    output logic [RTI_WORD_WIDTH-1:0]   rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [FIFO_DEPTH_LOG2:0]    fill_count,
    input  logic                        overflow_clear,
    output logic                        overflow_error,
    output logic [63:0]                 overflow_data
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    rti_entry_t             r_stage;
    logic                   r_stage_vld;
    logic                   r_ovf_err;
    logic [63:0]            r_ovf_data;

    logic                   w_sync_out;
    logic                   w_edge;
    logic                   w_rise;
    logic                   w_event;
    logic                   w_drop;
    rti_entry_t             w_head;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_sync_out ^ r_prev;
    assign w_rise     = w_sync_out & ~r_prev;
    assign w_event    = w_edge & capture_en &
                        ((w_rise & |(edge_mode & EDGE_RISE)) | (~w_rise & |(edge_mode & EDGE_FALL)));

    // The stage flop sees the counter LATENCY_COMP edges after ttl_in was sampled.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_sync      <= '0;
            r_prev      <= 1'b0;
            r_stage     <= '0;
            r_stage_vld <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], ttl_in};
            r_prev      <= w_sync_out;
            r_stage_vld <= w_event;
            if (w_event) begin
                r_stage.timestamp <= counter - 64'(LATENCY_COMP);
                r_stage.rising    <= w_rise;
            end
        end
    end

    ttl_rti_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .DATA_W     ($bits(rti_entry_t))
    ) u_fifo (
        .clk         (s_axi_aclk),
        .rst_n       (s_axi_aresetn),
        .i_push      (r_stage_vld),
        .i_push_data (r_stage),
        .i_pop       (rd_ready),
        .i_flush     (flush),
        .o_valid     (rd_valid),
        .o_data      (w_head),
        .o_full      (full),
        .o_empty     (empty),
        .o_count     (fill_count),
        .o_drop      (w_drop)
    );

    assign rd_data = rti_pack(w_head);

    // A fresh drop beats a simultaneous clear and refreshes the captured timestamp.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_ovf_err  <= 1'b0;
            r_ovf_data <= '0;
        end else if (w_drop && (!r_ovf_err || overflow_clear)) begin
            r_ovf_err  <= 1'b1;
            r_ovf_data <= r_stage.timestamp;
        end else if (overflow_clear) begin
            r_ovf_err  <= 1'b0;
        end
    end

    assign overflow_error = r_ovf_err;
    assign overflow_data  = r_ovf_data;

endmodule

// File: tb/tb_ttl_input_timestamper.sv
// Scoreboard bench: edges are modelled when ttl_in is driven; a monitor compares pops.
module tb_ttl_input_timestamper;

    localparam int DEPTH = 512;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         ttl_in = 1'b0;
    logic [63:0]  counter = 64'd0;
    logic         capture_en = 1'b0;
    logic [1:0]   edge_mode = 2'b00;
    logic         flush = 1'b0;
    logic         rd_ready = 1'b0;
    logic         overflow_clear = 1'b0;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         full;
    logic         empty;
    logic [9:0]   fill_count;
    logic         overflow_error;
    logic [63:0]  overflow_data;

    logic         cnt_ld = 1'b0;
    logic [63:0]  cnt_ld_val = 64'd0;

    typedef struct {
        logic [63:0] ts;
        logic        rising;
    } ev_t;

    ev_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        ttl_lvl = 1'b0;
    logic        exp_ovf_err = 1'b0;
    logic [63:0] exp_ovf_data = 64'd0;

    ttl_input_timestamper dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (rst_n),
        .ttl_in         (ttl_in),
        .counter        (counter),
        .capture_en     (capture_en),
        .edge_mode      (edge_mode),
        .flush          (flush),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .full           (full),
        .empty          (empty),
        .fill_count     (fill_count),
        .overflow_clear (overflow_clear),
        .overflow_error (overflow_error),
        .overflow_data  (overflow_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) counter <= cnt_ld ? cnt_ld_val : counter + 64'd1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] word(input logic [63:0] ts, input logic r);
        return {56'd0, ts, 7'd0, r};
    endfunction

    always @(negedge clk) begin : monitor
        ev_t e;
        #2;
        if (rst_n && rd_valid && rd_ready && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no entry", rd_data);
            end else begin
                e = sb.pop_front();
                check("pop_data", rd_data, word(e.ts, e.rising));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: the value driven is sampled at the next posedge,
    // where the counter still holds its current value.
    task automatic drive_ttl(input logic v, input bit will_pop = 1'b0);
        ev_t e;
        ttl_in = v;
        if (v !== ttl_lvl && capture_en && ((v && edge_mode[0]) || (!v && edge_mode[1]))) begin
            if (sb.size() >= DEPTH && !will_pop) begin
                if (!exp_ovf_err) begin
                    exp_ovf_err  = 1'b1;
                    exp_ovf_data = counter;
                end
            end else begin
                e.ts     = counter;
                e.rising = v;
                sb.push_back(e);
            end
        end
        ttl_lvl = v;
    endtask

    task automatic set_counter(input logic [63:0] v);
        cnt_ld_val = v;
        cnt_ld     = 1'b1;
        @(negedge clk);
        cnt_ld     = 1'b0;
    endtask

    task automatic drain(input int target, input int maxc);
        int i;
        i = 0;
        while (sb.size() > target && i < maxc) begin
            rd_ready = 1'b1;
            @(negedge clk);
            i++;
        end
        rd_ready = 1'b0;
        checks++;
        if (sb.size() != target) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected %0d", sb.size(), target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_fill"}, fill_count, 0);
        check({tag, "_ovf_err"}, overflow_error, 0);
        check({tag, "_ovf_data"}, overflow_data, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        tick(2);
        rst_n = 1'b1;
        capture_en = 1'b1;
        edge_mode  = 2'b11;
        tick(3);

        // rise at 1010, fall at 1020
        set_counter(64'd1000);
        tick(10);
        drive_ttl(1'b1);
        tick(4);
        check("latency_k3", rd_valid, 0);
        tick(1);
        check("latency_k4", rd_valid, 1);
        tick(5);
        drive_ttl(1'b0);
        tick(6);
        check("rf_count", fill_count, 2);
        check("rf_head", rd_data, word(64'd1010, 1'b1));
        drain(0, 20);

        // rising-only filtering, then capture disabled
        edge_mode = 2'b01;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            drive_ttl(~ttl_lvl);
            tick(1);
        end
        tick(6);
        check("filt_count", fill_count, 3);
        drain(0, 20);
        capture_en = 1'b0;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            drive_ttl(~ttl_lvl);
            tick(1);
        end
        tick(6);
        check("cap_off_empty", empty, 1);
        capture_en = 1'b1;

        // pointer wrap: 300 in, 300 out, twice
        edge_mode = 2'b11;
        tick(1);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 300; i++) begin
                drive_ttl(~ttl_lvl);
                tick(1);
            end
            tick(6);
            check("wrap_fill", fill_count, 300);
            drain(0, 400);
            tick(2);
            check("wrap_empty", empty, 1);
        end

        // fill to 512 and drop the 513th rising edge
        edge_mode = 2'b01;
        tick(4);
        set_counter(64'd5000);
        for (int i = 0; i < 1026; i++) begin
            if (i != 0) tick(1);
            drive_ttl(~ttl_lvl);
        end
        tick(6);
        check("ovf_full", full, 1);
        check("ovf_fill", fill_count, 512);
        check("ovf_err", overflow_error, 1);
        check("ovf_data", overflow_data, 64'd6024);
        check("ovf_model", exp_ovf_data, overflow_data);
        overflow_clear = 1'b1;
        tick(1);
        overflow_clear = 1'b0;
        exp_ovf_err    = 1'b0;
        check("ovf_cleared", overflow_error, 0);

        // push into a full FIFO on the same edge as a pop
        drive_ttl(1'b1, 1'b1);
        tick(3);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(3);
        check("pp_full", full, 1);
        check("pp_fill", fill_count, 512);
        check("pp_no_ovf", overflow_error, 0);
        drive_ttl(1'b0);
        tick(4);
        drain(10, 600);
        tick(1);
        check("pre_flush_fill", fill_count, 10);

        flush = 1'b1;
        sb.delete();
        tick(1);
        flush = 1'b0;
        check("flush_empty", empty, 1);
        check("flush_valid", rd_valid, 0);
        check("flush_fill", fill_count, 0);
        check("flush_ovf_err", overflow_error, exp_ovf_err);
        check("flush_ovf_data", overflow_data, exp_ovf_data);

        // randomized traffic with occasional mode changes
        for (int it = 0; it < 600; it++) begin
            if (it % 100 == 99) begin
                rd_ready = 1'b0;
                tick(4);
                capture_en = ($urandom_range(0, 3) != 0);
                edge_mode  = 2'($urandom_range(0, 3));
            end
            rd_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) drive_ttl(~ttl_lvl);
            tick(1);
        end
        rd_ready = 1'b0;
        tick(6);
        capture_en = 1'b1;
        drain(0, 700);
        tick(2);
        check("rand_empty", empty, 1);

        // asynchronous reset with entries held and one still in flight
        edge_mode = 2'b11;
        tick(1);
        for (int i = 0; i < 7; i++) begin
            drive_ttl(~ttl_lvl);
            tick(1);
        end
        tick(2);
        check("pre_rst_fill", fill_count, 6);
        #3;
        rst_n        = 1'b0;
        ttl_in       = 1'b0;
        ttl_lvl      = 1'b0;
        sb.delete();
        exp_ovf_err  = 1'b0;
        exp_ovf_data = 64'd0;
        #1 check_reset_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        drive_ttl(1'b1);
        tick(3);
        drive_ttl(1'b0);
        tick(6);
        check("post_rst_fill", fill_count, 2);
        drain(0, 20);
        tick(2);
        check("final_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
